spi_slave_rx_ctrl: RTL and testbench
====================================

# spi_slave_rx_ctrl

Receive-side controller of the SPI slave. It deserialises MOSI into 10-bit command words (2-bit command plus 8-bit payload) and hands them to the single-port RAM. On a read-data command, it captures the RAM's returned byte and issues a one-cycle load to the downstream parallel-to-serial MISO stage. It sits between the SPI pins and the RAM on the way in, and between the RAM and the MISO serialiser on the way out.

## Interface
- No parameters; frame length is fixed at 10 bits and the read payload at 8 bits.

Ports:
- clk  in  1  system clock; every MOSI bit is sampled on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ss_n  in  1  slave select, active low; frames are delimited by ss_n low.
- mosi  in  1  serial data in, MSB first.
- rx_data  out  10  received word {cmd[1:0], payload[7:0]}; held between rx_valid pulses.
- rx_valid  out  1  one-cycle strobe marking a new rx_data word.
- tx_data  in  8  read byte from RAM.
- tx_valid  in  1  qualifies tx_data.
- p2s_data  out  8  byte for the MISO serialiser.
- p2s_load  out  1  one-cycle load strobe to the serialiser.
- p2s_busy  in  1  serialiser busy flag.

## Operation
States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE:
  - Goes to CHK_CMD on the first edge where ss_n = 0.
  - No bit is sampled on that edge.
- CHK_CMD:
  - Samples mosi as bit 9 and sets bit count to 1.
  - Next state: mosi = 0 -> WRITE; mosi = 1 and rd_addr_seen = 0 -> READ_ADD; mosi = 1 and rd_addr_seen = 1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA sampling:
  - Shift mosi into rx shift register while count < 10; count is 4 bits and saturates at 10.
  - Bits after the 10th are ignored until ss_n rises.
- Frame completion:
  - When count reaches 10, rx_data <= shift register and rx_valid is pulsed.
  - In READ_ADD, completion also sets rd_addr_seen = 1.
- READ_DATA, after its rx_valid:
  - Waits for tx_valid = 1, then latches tx_data into p2s_data and sets load_pending.
  - While load_pending and p2s_busy = 0: pulse p2s_load for one cycle, clear load_pending, clear rd_addr_seen.
  - tx_valid seen before frame completion, or a second time in the same frame, is ignored.
- ss_n = 1 in any non-IDLE state:
  - Next state is IDLE; count and load_pending are cleared.
  - A partial frame is discarded with no rx_valid.
  - rd_addr_seen is retained.
  - A load already pulsed is not recalled.
- rx_data is not cleared between frames.
- Reset (asynchronous, at any time, including mid-frame or mid-load):
  - State IDLE, count 0, rd_addr_seen 0, load_pending 0.
  - Outputs: rx_data 0, rx_valid 0, p2s_data 0, p2s_load 0.

## Timing
- The ss_n falling edge is observed at edge E0.
- Bit 9 is sampled at E1, bit 0 at E10.
- rx_valid is high for exactly the cycle after E10, i.e. it is registered at E10. Latency from the last bit to strobe is 1 clock.
- tx_valid high at edge T -> p2s_load high in the cycle after T if p2s_busy = 0 at T; otherwise it is delayed until the first edge sampling p2s_busy = 0.
- p2s_data is valid no later than p2s_load and is held until the next load.
- Edges where ss_n and tx_valid change together:
  - ss_n = 1 and the 10th bit on the same edge: frame dropped, no rx_valid.
  - ss_n = 1 and tx_valid on the same edge: ss_n wins, no load.
- Minimum gap between frames: 1 cycle of ss_n high.

## Test plan
- Write address: ss_n low, shift 00_1010_0101 -> rx_data = 0x0A5 with a single rx_valid pulse 1 clock after the 10th bit; p2s_load stays 0.
- Write data: shift 01_0011_1100 -> rx_data = 0x13C, rx_valid a single pulse; extra 3 bits before ss_n rises produce no second pulse.
- Read address then read data:
  - Frame 10_0000_0111 -> rx_data = 0x207, rd_addr_seen = 1.
  - Next frame 11_0000_0000 -> rx_data = 0x300.
  - tx_valid with tx_data = 0xC3 -> p2s_data = 0xC3, p2s_load one cycle later, rd_addr_seen = 0.
- Busy hold-off: same read-data frame with p2s_busy = 1 for 5 cycles after tx_valid -> p2s_load is asserted exactly 1 cycle after busy falls, once only.
- Abort: ss_n rises after 6 bits of a write frame -> no rx_valid, state IDLE; the following full frame 01_1111_1111 -> rx_data = 0x1FF.
- Reset mid-frame: rst pulsed after 4 bits of a READ_ADD frame -> all outputs 0 immediately, rd_addr_seen 0; a subsequent frame beginning with bit 1 enters READ_ADD.

Source files
------------

// File: rtl/spi_slave_rx_ctrl.sv
// SPI slave receive controller: deserialises 10-bit command frames from MOSI
// and forwards RAM read bytes to the MISO parallel-to-serial stage.
module spi_slave_rx_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_n,
  input  logic       mosi,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic [7:0] p2s_data,
  output logic       p2s_load,
  input  logic       p2s_busy
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  shift_q, shift_d;
  logic [9:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  p2s_data_q, p2s_data_d;
  logic        p2s_load_q, p2s_load_d;
  logic        rd_addr_seen_q, rd_addr_seen_d;
  logic        load_pending_q, load_pending_d;
  logic        tx_seen_q, tx_seen_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      p2s_data_q     <= '0;
      p2s_load_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      load_pending_q <= 1'b0;
      tx_seen_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      p2s_data_q     <= p2s_data_d;
      p2s_load_q     <= p2s_load_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      load_pending_q <= load_pending_d;
      tx_seen_q      <= tx_seen_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    p2s_data_d     = p2s_data_q;
    p2s_load_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    load_pending_d = load_pending_q;
    tx_seen_d      = tx_seen_q;

    if (state_q == IDLE) begin
      if (!ss_n) state_d = CHK_CMD;
    end else if (ss_n) begin
      // Deselect beats everything sampled on the same edge: last bit, tx_valid, pending load.
      state_d        = IDLE;
      cnt_d          = '0;
      load_pending_d = 1'b0;
      tx_seen_d      = 1'b0;
    end else if (state_q == CHK_CMD) begin
      shift_d   = {shift_q[8:0], mosi};
      cnt_d     = 4'd1;
      tx_seen_d = 1'b0;
      if (!mosi)               state_d = WRITE;
      else if (rd_addr_seen_q) state_d = READ_DATA;
      else                     state_d = READ_ADD;
    end else begin
      if (cnt_q < 4'd10) begin
        shift_d = {shift_q[8:0], mosi};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          rx_data_d  = {shift_q[8:0], mosi};
          rx_valid_d = 1'b1;
          if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
        end
      end
      // Read byte accepted once per frame, only after the frame has completed.
      if (state_q == READ_DATA && cnt_q == 4'd10) begin
        if (tx_valid && !tx_seen_q) begin
          p2s_data_d = tx_data;
          tx_seen_d  = 1'b1;
          if (!p2s_busy) begin
            p2s_load_d     = 1'b1;
            rd_addr_seen_d = 1'b0;
          end else begin
            load_pending_d = 1'b1;
          end
        end else if (load_pending_q && !p2s_busy) begin
          p2s_load_d     = 1'b1;
          load_pending_d = 1'b0;
          rd_addr_seen_d = 1'b0;
        end
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign p2s_data = p2s_data_q;
  assign p2s_load = p2s_load_q;

endmodule

// File: tb/tb_spi_slave_rx_ctrl.sv
// Directed bench for spi_slave_rx_ctrl with scoreboard queues for rx words and p2s loads.
module tb_spi_slave_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [7:0] p2s_data;
  logic       p2s_load;
  logic       p2s_busy;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_rx[$];
  logic [7:0] exp_p2s[$];

  spi_slave_rx_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .p2s_data (p2s_data),
    .p2s_load (p2s_load),
    .p2s_busy (p2s_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        chk("rx_pulse_expected", 32'(exp_rx.size() > 0), 32'd1);
        if (exp_rx.size() > 0) chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
      if (p2s_load) begin
        chk("p2s_pulse_expected", 32'(exp_p2s.size() > 0), 32'd1);
        if (exp_p2s.size() > 0) chk("p2s_data", 32'(p2s_data), 32'(exp_p2s.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Leaves ss_n low; returns 1 time unit after the edge that sampled the last driven bit.
  task automatic frame(input logic [9:0] w, input int nbits, input bit complete);
    @(negedge clk) ss_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) mosi = w[9-i];
    end
    if (complete) exp_rx.push_back(w);
    @(posedge clk) #1;
    chk("rx_valid_timing", 32'(rx_valid), complete ? 32'd1 : 32'd0);
  endtask

  task automatic end_frame();
    @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
  endtask

  task automatic pulse_tx(input logic [7:0] d, input logic busy, input bit expect_load);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    p2s_busy = busy;
    if (expect_load) exp_p2s.push_back(d);
    @(posedge clk) #1;
    chk("p2s_load_after_tx", 32'(p2s_load), expect_load ? 32'd1 : 32'd0);
    @(negedge clk) tx_valid = 1'b0;
    @(posedge clk) #1;
    chk("p2s_load_single", 32'(p2s_load), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; p2s_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_p2s_data", 32'(p2s_data), 32'd0);
    chk("reset_p2s_load", 32'(p2s_load), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write address
    frame(10'h0A5, 10, 1'b1);
    @(posedge clk) #1;
    chk("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
    end_frame();

    // Write data with three trailing bits that must be ignored
    frame(10'h13C, 10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) mosi = 1'b1;
      @(posedge clk) #1;
      chk("extra_bits_no_pulse", 32'(rx_valid), 32'd0);
    end
    end_frame();

    // Read address, then read data with an immediate load
    frame(10'h207, 10, 1'b1);
    end_frame();
    frame(10'h300, 10, 1'b1);
    pulse_tx(8'hC3, 1'b0, 1'b1);
    chk("p2s_data_held", 32'(p2s_data), 32'h0C3);
    pulse_tx(8'h11, 1'b0, 1'b0);
    chk("p2s_data_not_overwritten", 32'(p2s_data), 32'h0C3);
    end_frame();

    // rd_addr_seen cleared by the load: cmd 11 now acts as read address
    frame(10'h300, 10, 1'b1);
    pulse_tx(8'h99, 1'b0, 1'b0);
    end_frame();

    // Busy hold-off on read data
    frame(10'h300, 10, 1'b1);
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h5A; p2s_busy = 1'b1;
    exp_p2s.push_back(8'h5A);
    @(posedge clk) #1;
    chk("busy_no_load", 32'(p2s_load), 32'd0);
    @(negedge clk) tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk) #1;
      chk("busy_no_load", 32'(p2s_load), 32'd0);
    end
    @(negedge clk) p2s_busy = 1'b0;
    @(posedge clk) #1;
    chk("load_after_busy", 32'(p2s_load), 32'd1);
    chk("busy_p2s_data", 32'(p2s_data), 32'h05A);
    @(posedge clk) #1;
    chk("load_after_busy_once", 32'(p2s_load), 32'd0);
    end_frame();

    // ss_n rising together with tx_valid: no load, rd_addr_seen retained
    frame(10'h2AA, 10, 1'b1);
    end_frame();
    frame(10'h3FF, 10, 1'b1);
    @(negedge clk);
    ss_n = 1'b1; tx_valid = 1'b1; tx_data = 8'hEE;
    @(posedge clk) #1;
    chk("ss_n_beats_tx_valid", 32'(p2s_load), 32'd0);
    @(negedge clk) tx_valid = 1'b0;
    frame(10'h301, 10, 1'b1);
    pulse_tx(8'h77, 1'b0, 1'b1);
    end_frame();

    // Abort after 6 bits, then a full frame
    frame(10'h1FF, 6, 1'b0);
    end_frame();
    frame(10'h1FF, 10, 1'b1);
    end_frame();

    // ss_n rising on the 10th-bit edge drops the frame
    frame(10'h055, 9, 1'b0);
    @(negedge clk);
    mosi = 1'b1; ss_n = 1'b1;
    @(posedge clk) #1;
    chk("ss_n_on_last_bit", 32'(rx_valid), 32'd0);
    chk("rx_data_retained", 32'(rx_data), 32'h1FF);

    // Reset mid-frame with rd_addr_seen set beforehand
    frame(10'h207, 10, 1'b1);
    end_frame();
    frame(10'h2F0, 4, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_rx_data", 32'(rx_data), 32'd0);
    chk("rst_async_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_async_p2s_data", 32'(p2s_data), 32'd0);
    chk("rst_async_p2s_load", 32'(p2s_load), 32'd0);
    @(negedge clk);
    ss_n = 1'b1; mosi = 1'b0;
    @(negedge clk) rst = 1'b0;
    frame(10'h300, 10, 1'b1);
    pulse_tx(8'h42, 1'b0, 1'b0);
    end_frame();
    frame(10'h300, 10, 1'b1);
    pulse_tx(8'h42, 1'b0, 1'b1);
    end_frame();

    repeat (3) @(negedge clk);
    chk("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    chk("p2s_queue_drained", 32'(exp_p2s.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
